// File: rtl/apb_rr_master_pkg.sv
// Shared types and width defaults for the round-robin APB master.
package apb_rr_master_pkg;

    localparam int APB_ADDR_WIDTH = 10;
    localparam int APB_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/apb_rr_master_arb.sv
// Combinational round-robin arbiter: first valid requester at or after last_grant+1.
module apb_rr_arb #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant_i,
    output logic [NUM_REQ-1:0]         grant_oh_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
    output logic                       grant_any_o
);

    localparam int IDX_W = $clog2(NUM_REQ);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last_grant_i) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!grant_any_o && req_valid_i[cand_idx]) begin
                grant_any_o          = 1'b1;
                grant_idx_o          = cand_idx;
                grant_oh_o[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ requesters onto one APB slave,
// one SETUP/ACCESS transfer at a time, with an ACCESS timeout abort.
module apb_rr_master
    import apb_rr_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = APB_DATA_WIDTH,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          pclk,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic                          pwrite,
    output logic                          psel,
    output logic                          penable,
    output logic [DATA_WIDTH-1:0]         pwdata,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_t                  state_q;
    logic [IDX_W-1:0]        gnt_q;
    logic [IDX_W-1:0]        last_grant_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    logic [NUM_REQ-1:0]      grant_oh;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_any;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic                    sel_write;
    logic [NUM_REQ-1:0]      gnt_oh;

    apb_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_valid_i  (req_valid),
        .last_grant_i (last_grant_q),
        .grant_oh_o   (grant_oh),
        .grant_idx_o  (grant_idx),
        .grant_any_o  (grant_any)
    );

    assign sel_addr  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_write = req_write[grant_idx];
    assign gnt_oh    = NUM_REQ'(1) << gnt_q;

    // Acceptance is the same-cycle valid/ready handshake in IDLE; masked while in reset.
    assign req_ready = (PRESETn && state_q == IDLE) ? grant_oh : '0;

    always_ff @(posedge pclk or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            last_grant_q <= IDX_LAST;
            cnt_q        <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state_q)
                IDLE: begin
                    if (grant_any) begin
                        gnt_q        <= grant_idx;
                        last_grant_q <= grant_idx;
                        paddr_q      <= sel_addr;
                        pwrite_q     <= sel_write;
                        pwdata_q     <= sel_write ? sel_wdata : '0;
                        psel_q       <= 1'b1;
                        state_q      <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= gnt_oh;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= 1'b0;
                        state_q     <= RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= gnt_oh;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Self-checking bench: memory slave with programmable pready delay, directed
// scenarios plus randomized rounds checked against a round-robin/memory model.
module tb_apb_rr_master;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int TO = 16;

    logic              pclk = 1'b0;
    logic              PRESETn;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata, pwdata, prdata;
    logic              rsp_err, pwrite, psel, penable, pready;
    logic [AW-1:0]     paddr;

    always #5 pclk = ~pclk;

    apb_rr_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    // Slave: memory with pready after stub_wait ACCESS cycles, or never when stuck.
    logic [DW-1:0] slv_mem [1<<AW];
    int            stub_wait = 0;
    bit            stuck = 1'b0;
    int            acc_cnt = 0;

    assign pready = psel && penable && !stuck && (acc_cnt >= stub_wait);
    assign prdata = pready ? slv_mem[paddr] : 32'hBAD0_BAD0;

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else                            acc_cnt <= 0;
        if (psel && penable && pready && pwrite) slv_mem[paddr] <= pwdata;
    end

    // Protocol monitor.
    int cyc = 0, proto_err = 0, setups = 0, acc_len = 0, last_acc_len = 0, rsp_seen = 0, g1_seen = 0;
    logic          prev_psel = 1'b0, prev_pen = 1'b0, prev_wr = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_wd = '0;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (PRESETn) begin
            if ((penable && !psel) ||
                (penable && !prev_pen && !(prev_psel && !prev_pen)) ||
                (prev_psel && !prev_pen && !penable) ||
                (prev_pen && penable && (paddr != prev_addr || pwrite != prev_wr || pwdata != prev_wd)) ||
                (psel && !pwrite && pwdata != '0))
                proto_err <= proto_err + 1;
            if (psel && !penable && !prev_psel) setups <= setups + 1;
            if (psel && penable) acc_len <= acc_len + 1;
            else if (prev_pen) begin
                last_acc_len <= acc_len;
                acc_len      <= 0;
            end
            if (rsp_valid != '0) rsp_seen <= rsp_seen + 1;
            if (req_ready[1])    g1_seen  <= g1_seen + 1;
        end else begin
            acc_len <= 0;
        end
        prev_psel <= psel;
        prev_pen  <= penable;
        prev_addr <= paddr;
        prev_wr   <= pwrite;
        prev_wd   <= pwdata;
    end

    // Reference model: next-priority pointer, memory image, requester fields.
    int            mdl_prio = 0;
    logic [DW-1:0] ref_mem [1<<AW];
    bit            fw [NR];
    logic [AW-1:0] fa [NR];
    logic [DW-1:0] fd [NR];

    int            checks = 0, errors = 0;
    int            first_grant = -1;
    logic [DW-1:0] last_rdata = '0;
    logic          last_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] m);
        for (int k = 0; k < NR; k++) begin
            int i = (mdl_prio + k) % NR;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        fw[r] = w; fa[r] = a; fd[r] = d;
        req_write[r]          = w;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic do_reset();
        PRESETn   = 1'b0;
        req_valid = '0;
        stuck     = 1'b0;
        stub_wait = 0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        PRESETn  = 1'b1;
        mdl_prio = 0;
    endtask

    // Raise all requesters in mask; each drops valid right after its grant.
    task automatic run_round(input logic [NR-1:0] mask, input int waits, input bit stk);
        logic [NR-1:0] pending;
        bit            outstanding;
        int            cur, acc_cyc, exp_lat, budget, g;
        logic [DW-1:0] exp_rd;
        logic          exp_err;
        pending = mask; outstanding = 1'b0; cur = 0; acc_cyc = 0; exp_lat = 0;
        budget = 0; exp_rd = '0; exp_err = 1'b0;
        stub_wait = waits;
        stuck     = stk;
        @(posedge pclk); #1;
        req_valid = mask;
        while ((pending != '0 || outstanding) && budget < 400) begin
            @(negedge pclk);
            budget++;
            if (req_ready != '0) begin
                g = pick(pending);
                if (g < 0) begin
                    check("spurious_grant", 32'(req_ready), 32'd0);
                end else begin
                    check("grant", 32'(req_ready), 32'd1 << g);
                    if (pending == mask) first_grant = g;
                    cur = g; acc_cyc = cyc; outstanding = 1'b1;
                    pending[g] = 1'b0;
                    mdl_prio = (g + 1) % NR;
                    if (stk) begin
                        exp_rd = '0; exp_err = 1'b1; exp_lat = 3 + TO - 1;
                    end else begin
                        exp_err = 1'b0; exp_lat = 3 + waits;
                        if (fw[g]) begin
                            ref_mem[fa[g]] = fd[g];
                            exp_rd = '0;
                        end else begin
                            exp_rd = ref_mem[fa[g]];
                        end
                    end
                end
            end
            if (rsp_valid != '0) begin
                check("rsp_onehot", 32'(rsp_valid), 32'd1 << cur);
                check("rsp_rdata", rsp_rdata, exp_rd);
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                check("rsp_latency", cyc - acc_cyc, exp_lat);
                last_rdata  = rsp_rdata;
                last_err    = rsp_err;
                outstanding = 1'b0;
            end
            @(posedge pclk); #1;
            req_valid = req_valid & pending;
        end
        check("round_done", 32'(pending == '0 && !outstanding), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr, nrsp, s0, g1, rs, budget;
        int exp_seq [6] = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < (1 << AW); i++) begin
            slv_mem[i] = '0;
            ref_mem[i] = '0;
        end
        slv_mem[10'h3FF] = 32'h1234_5678;
        ref_mem[10'h3FF] = 32'h1234_5678;
        PRESETn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int r = 0; r < NR; r++) set_req(r, 1'b0, '0, '0);

        // Reset state, with requests pending to show req_ready is masked.
        repeat (2) @(posedge pclk);
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_psel", 32'(psel), 32'd0);
        check("rst_penable", 32'(penable), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_paddr", 32'(paddr), 32'd0);
        check("rst_pwdata", pwdata, 32'd0);
        check("rst_pwrite", 32'(pwrite), 32'd0);
        do_reset();

        // Single write then read back.
        set_req(0, 1'b1, 10'h005, 32'hDEAD_BEEF);
        run_round(2'b01, 0, 1'b0);
        set_req(0, 1'b0, 10'h005, 32'h0);
        run_round(2'b01, 0, 1'b0);
        check("wr_rd_data", last_rdata, 32'hDEAD_BEEF);

        // Contention: both requesters valid continuously for 6 transfers.
        do_reset();
        set_req(0, 1'b1, 10'h010, 32'h1111_0000);
        set_req(1, 1'b1, 10'h011, 32'h2222_0000);
        ngr = 0; nrsp = 0; budget = 0;
        @(posedge pclk); #1;
        req_valid = 2'b11;
        while (nrsp < 6 && budget < 200) begin
            @(negedge pclk);
            budget++;
            if (req_ready != '0 && ngr < 6) begin
                check("contention_grant", 32'(req_ready), 32'd1 << exp_seq[ngr]);
                ref_mem[fa[exp_seq[ngr]]] = fd[exp_seq[ngr]];
                mdl_prio = (exp_seq[ngr] + 1) % NR;
                ngr++;
            end
            if (rsp_valid != '0) begin
                check("contention_rdata", rsp_rdata, 32'd0);
                nrsp++;
            end
            @(posedge pclk); #1;
            if (ngr >= 6) req_valid = '0;
        end
        check("contention_done", nrsp, 6);
        check("contention_proto", proto_err, 0);

        // Wait states: 3 cycles of pready low on read of 0x3FF.
        set_req(0, 1'b0, 10'h3FF, 32'h0);
        run_round(2'b01, 3, 1'b0);
        check("wait_rdata", last_rdata, 32'h1234_5678);
        check("wait_err", 32'(last_err), 32'd0);
        check("wait_access_len", last_acc_len, 4);

        // Timeout with pready stuck low, then a normal transfer.
        run_round(2'b01, 0, 1'b1);
        check("timeout_err", 32'(last_err), 32'd1);
        check("timeout_rdata", last_rdata, 32'd0);
        check("timeout_access_len", last_acc_len, TO);
        set_req(0, 1'b0, 10'h005, 32'h0);
        run_round(2'b01, 0, 1'b0);
        check("post_timeout_rdata", last_rdata, 32'hDEAD_BEEF);
        check("post_timeout_err", 32'(last_err), 32'd0);

        // Withdrawn request: req1 pulses valid while req0 is in flight.
        s0 = setups; g1 = g1_seen; budget = 0;
        stub_wait = 3;
        set_req(0, 1'b0, 10'h005, 32'h0);
        set_req(1, 1'b1, 10'h066, 32'hCAFE_F00D);
        @(posedge pclk); #1;
        req_valid = 2'b01;
        do begin @(negedge pclk); budget++; end while (!req_ready[0] && budget < 20);
        check("withdraw_grant0", 32'(req_ready), 32'd1);
        mdl_prio = 1;
        @(posedge pclk); #1;
        req_valid = 2'b10;
        @(posedge pclk); #1;
        req_valid = 2'b00;
        budget = 0;
        do begin @(negedge pclk); budget++; end while (rsp_valid == '0 && budget < 40);
        check("withdraw_rsp_valid", 32'(rsp_valid), 32'd1);
        check("withdraw_rdata", rsp_rdata, 32'hDEAD_BEEF);
        repeat (8) @(posedge pclk);
        #1;
        check("withdraw_setups", setups, s0 + 1);
        check("withdraw_no_grant1", g1_seen, g1);

        // Reset during ACCESS of req1.
        set_req(1, 1'b0, 10'h055, 32'h0);
        stuck = 1'b1; stub_wait = 0; budget = 0;
        @(posedge pclk); #1;
        req_valid = 2'b10;
        do begin @(negedge pclk); budget++; end while (!req_ready[1] && budget < 20);
        check("midrst_grant1", 32'(req_ready), 32'd2);
        @(posedge pclk); #1;
        req_valid = '0;
        budget = 0;
        do begin @(negedge pclk); budget++; end while (!(psel && penable) && budget < 20);
        check("midrst_in_access", 32'(psel && penable), 32'd1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("midrst_psel", 32'(psel), 32'd0);
        check("midrst_penable", 32'(penable), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        rs = rsp_seen;
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        PRESETn = 1'b1; stuck = 1'b0; mdl_prio = 0;
        repeat (5) @(posedge pclk);
        #1;
        check("midrst_no_rsp", rsp_seen, rs);
        set_req(0, 1'b0, 10'h3FF, 32'h0);
        run_round(2'b11, 0, 1'b0);
        check("midrst_first_grant", first_grant, 0);

        // Randomized rounds against the model.
        for (int n = 0; n < 12; n++) begin
            for (int r = 0; r < NR; r++)
                set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, (1 << AW) - 1)), $urandom());
            run_round(NR'($urandom_range(1, (1 << NR) - 1)), int'($urandom_range(0, 3)), 1'b0);
        end

        check("protocol_errors", proto_err, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
